// File: rtl/async_mem_master.sv
// Single-beat bus initiator for asynchronous ROM/SRAM parts (A, CS_bar, OE_bar, WE_bar, D).
// Read latency READ_WAIT cycles, write latency WRITE_SETUP+WRITE_PULSE+WRITE_HOLD; req_ready only in IDLE.
module async_mem_master #(
   parameter int ADDR_WIDTH  = 15,
   parameter int READ_WAIT   = 2,
   parameter int WRITE_SETUP = 1,
   parameter int WRITE_PULSE = 2,
   parameter int WRITE_HOLD  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [7:0]            req_wdata,
   output logic                  req_ready,
   output logic                  rsp_valid,
   output logic [7:0]            rsp_rdata,
   output logic [ADDR_WIDTH-1:0] A,
   inout  wire  [7:0]            D,
   output logic                  CS_bar,
   output logic                  OE_bar,
   output logic                  WE_bar
);

   localparam int M1   = (READ_WAIT > WRITE_SETUP) ? READ_WAIT : WRITE_SETUP;
   localparam int M2   = (WRITE_PULSE > WRITE_HOLD) ? WRITE_PULSE : WRITE_HOLD;
   localparam int MAXP = (M1 > M2) ? M1 : M2;
   localparam int CW   = $clog2(MAXP + 1);

   localparam logic [CW-1:0] RD_LOAD    = CW'(READ_WAIT - 1);
   localparam logic [CW-1:0] SETUP_LOAD = CW'(WRITE_SETUP - 1);
   localparam logic [CW-1:0] PULSE_LOAD = CW'(WRITE_PULSE - 1);
   localparam logic [CW-1:0] HOLD_LOAD  = CW'((WRITE_HOLD > 0) ? WRITE_HOLD - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR_SETUP,
      S_WR_PULSE,
      S_WR_HOLD
   } state_t;

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [7:0]            r_wdata;
   logic                  r_d_oe;
   logic                  r_cs_bar;
   logic                  r_oe_bar;
   logic                  r_we_bar;
   logic                  r_rsp_valid;
   logic [7:0]            r_rsp_rdata;
   logic                  w_cnt_done;

   assign w_cnt_done = (r_cnt == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_d_oe      <= 1'b0;
         r_cs_bar    <= 1'b1;
         r_oe_bar    <= 1'b1;
         r_we_bar    <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_addr   <= req_addr;
                  r_cs_bar <= 1'b0;
                  if (req_we) begin
                     r_wdata <= req_wdata;
                     r_d_oe  <= 1'b1;
                     r_cnt   <= SETUP_LOAD;
                     r_state <= S_WR_SETUP;
                  end else begin
                     r_oe_bar <= 1'b0;
                     r_cnt    <= RD_LOAD;
                     r_state  <= S_RD;
                  end
               end
            end
            S_RD: begin
               if (w_cnt_done) begin
                  // D is sampled while OE_bar is still low on this edge
                  r_rsp_rdata <= D;
                  r_rsp_valid <= 1'b1;
                  r_cs_bar    <= 1'b1;
                  r_oe_bar    <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_WR_SETUP: begin
               if (w_cnt_done) begin
                  r_we_bar <= 1'b0;
                  r_cnt    <= PULSE_LOAD;
                  r_state  <= S_WR_PULSE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_WR_PULSE: begin
               if (w_cnt_done) begin
                  r_we_bar <= 1'b1;
                  if (WRITE_HOLD > 0) begin
                     r_cnt   <= HOLD_LOAD;
                     r_state <= S_WR_HOLD;
                  end else begin
                     // no hold phase: CS_bar rises with WE_bar
                     r_cs_bar    <= 1'b1;
                     r_d_oe      <= 1'b0;
                     r_rsp_valid <= 1'b1;
                     r_state     <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_WR_HOLD: begin
               if (w_cnt_done) begin
                  r_cs_bar    <= 1'b1;
                  r_d_oe      <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign A         = r_addr;
   assign CS_bar    = r_cs_bar;
   assign OE_bar    = r_oe_bar;
   assign WE_bar    = r_we_bar;
   assign D         = r_d_oe ? r_wdata : 8'bz;

endmodule

// File: tb/tb_async_mem_master.sv
// Bench for async_mem_master: vector table, hand-written corner sequences, randomized traffic vs reference memory.
module tb_async_mem_master;

   localparam int AW = 15;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_valid0 = 1'b0;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [7:0]    req_wdata = '0;

   wire           req_ready, rsp_valid, CS_bar, OE_bar, WE_bar;
   wire [7:0]     rsp_rdata, D;
   wire [AW-1:0]  A;
   wire           req_ready0, rsp_valid0, CS_bar0, OE_bar0, WE_bar0;
   wire [7:0]     rsp_rdata0, D0;
   wire [AW-1:0]  A0;

   async_mem_master #(.ADDR_WIDTH(AW), .READ_WAIT(2), .WRITE_SETUP(1), .WRITE_PULSE(2), .WRITE_HOLD(1)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .A(A), .D(D), .CS_bar(CS_bar), .OE_bar(OE_bar), .WE_bar(WE_bar));

   async_mem_master #(.ADDR_WIDTH(AW), .READ_WAIT(2), .WRITE_SETUP(1), .WRITE_PULSE(2), .WRITE_HOLD(0)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid0), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready0), .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0),
      .A(A0), .D(D0), .CS_bar(CS_bar0), .OE_bar(OE_bar0), .WE_bar(WE_bar0));

   always #5 clk = ~clk;

   // Memory chip models; other bus devices hold 0x5A on D while the chip is deselected.
   logic [7:0] mem  [0:32767];
   logic [7:0] mem0 [0:32767];
   logic       bus_en, bus_en0;
   logic [7:0] bus_val, bus_val0;

   always_comb begin
      bus_en   = CS_bar | ~OE_bar;
      bus_val  = CS_bar ? 8'h5A : mem[A];
      bus_en0  = CS_bar0 | ~OE_bar0;
      bus_val0 = CS_bar0 ? 8'h5A : mem0[A0];
   end
   assign D  = bus_en  ? bus_val  : 8'bz;
   assign D0 = bus_en0 ? bus_val0 : 8'bz;

   always @(negedge clk) begin
      if (!rst && !CS_bar && !WE_bar) mem[A] = D;
      if (!rst && !CS_bar0 && !WE_bar0) mem0[A0] = D0;
   end

   // Bus-protocol invariants on the main instance
   int            viol = 0;
   logic          prev_cs_low = 1'b0;
   logic [AW-1:0] prev_a;
   logic [7:0]    prev_d;
   always @(negedge clk) begin
      if (rst) begin
         prev_cs_low = 1'b0;
      end else begin
         if (!WE_bar && CS_bar) viol++;
         if (!WE_bar && !OE_bar) viol++;
         if (CS_bar && D !== 8'h5A) viol++;
         if (!CS_bar && prev_cs_low && (A !== prev_a || D !== prev_d)) viol++;
         prev_cs_low = !CS_bar;
         prev_a      = A;
         prev_d      = D;
      end
   end

   int tests = 0;
   int failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Issue one request on the main instance; called and returns at #1 after a clock edge.
   task automatic do_txn(input logic we, input logic [AW-1:0] a, input logic [7:0] wd,
                         output int lat, output int cs_n, output int oe_n, output int we_n,
                         output int rdy_n);
      int g;
      req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd;
      g = 0;
      while (!req_ready && g < 50) begin
         @(posedge clk); #1; g++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = 8'($urandom);
      lat = -1; cs_n = 0; oe_n = 0; we_n = 0; rdy_n = 0;
      for (int k = 0; k < 50; k++) begin
         if (rsp_valid) begin
            lat = k;
            break;
         end
         cs_n  += int'(!CS_bar);
         oe_n  += int'(!OE_bar);
         we_n  += int'(!WE_bar);
         rdy_n += int'(req_ready);
         @(posedge clk); #1;
      end
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [7:0]    wd;
      logic [7:0]    rd;
      int            lat;
      int            cs;
      int            stb;
   } vec_t;

   vec_t       tbl [8];
   logic [7:0] ref_mem [16];

   initial begin
      int lat, cs_n, oe_n, we_n, rdy_n;
      int acc, gap, phase, nrsp, busy, cnt;
      logic r;
      logic [7:0] last_rd, exp_rd, rdv;
      logic last_we;
      int idx;
      logic wr;
      logic [7:0] wd;

      tbl[0] = '{1'b0, 15'h1234, 8'h00, 8'hA5, 2, 2, 2};
      tbl[1] = '{1'b1, 15'h0010, 8'h3C, 8'hA5, 4, 4, 2};
      tbl[2] = '{1'b0, 15'h0010, 8'h00, 8'h3C, 2, 2, 2};
      tbl[3] = '{1'b1, 15'h7FFF, 8'hC3, 8'h3C, 4, 4, 2};
      tbl[4] = '{1'b0, 15'h7FFF, 8'h00, 8'hC3, 2, 2, 2};
      tbl[5] = '{1'b1, 15'h0000, 8'hFF, 8'hC3, 4, 4, 2};
      tbl[6] = '{1'b0, 15'h0000, 8'h00, 8'hFF, 2, 2, 2};
      tbl[7] = '{1'b0, 15'h1234, 8'h00, 8'hA5, 2, 2, 2};

      for (int i = 0; i < 32768; i++) begin
         mem[i]  = 8'h00;
         mem0[i] = 8'h00;
      end
      mem[15'h1234] = 8'hA5;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i]      = 8'($urandom);
         mem[16'h100 + i] = ref_mem[i];
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_cs_bar", 32'(CS_bar), 1);
      check("rst_oe_bar", 32'(OE_bar), 1);
      check("rst_we_bar", 32'(WE_bar), 1);
      check("rst_addr", 32'(A), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_rdata", 32'(rsp_rdata), 0);
      check("rst_d_released", 32'(D), 32'h5A);
      #3 rst = 1'b0;
      #1;
      check("rst_req_ready", 32'(req_ready), 1);
      @(posedge clk); #1;

      // Vector table
      for (int i = 0; i < 8; i++) begin
         do_txn(tbl[i].we, tbl[i].addr, tbl[i].wd, lat, cs_n, oe_n, we_n, rdy_n);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
         check($sformatf("v%0d_rdata", i), 32'(rsp_rdata), 32'(tbl[i].rd));
         check($sformatf("v%0d_cs_cycles", i), 32'(cs_n), 32'(tbl[i].cs));
         check($sformatf("v%0d_strobe_cycles", i), 32'(tbl[i].we ? we_n : oe_n), 32'(tbl[i].stb));
         check($sformatf("v%0d_wrong_strobe", i), 32'(tbl[i].we ? oe_n : we_n), 0);
         check($sformatf("v%0d_busy_ready", i), 32'(rdy_n), 0);
         check($sformatf("v%0d_ready_at_rsp", i), 32'(req_ready), 1);
         @(posedge clk); #1;
         check($sformatf("v%0d_rsp_pulse", i), 32'(rsp_valid), 0);
      end

      // Back-to-back: write 0x7FFF then read it with req_valid held high
      req_valid = 1'b1; req_we = 1'b1; req_addr = 15'h7FFF; req_wdata = 8'h96;
      acc = 0; gap = 0; phase = 0; nrsp = 0; busy = 0; rdv = 8'h00;
      for (int k = 0; k < 40; k++) begin
         r = req_ready;
         @(posedge clk); #1;
         if (r && req_valid) begin
            acc++;
            if (acc == 1) req_we = 1'b0;
            else req_valid = 1'b0;
         end
         case (phase)
            0: if (!CS_bar) phase = 1;
            1: if (CS_bar) begin phase = 2; gap = 1; end
            2: if (CS_bar && OE_bar && WE_bar) gap++; else phase = 3;
            default: ;
         endcase
         if (!CS_bar && req_ready) busy++;
         if (rsp_valid) begin nrsp++; rdv = rsp_rdata; end
      end
      check("b2b_accepts", 32'(acc), 2);
      check("b2b_idle_gap", 32'(gap), 1);
      check("b2b_responses", 32'(nrsp), 2);
      check("b2b_read_data", 32'(rdv), 32'h96);
      check("b2b_busy_ready", 32'(busy), 0);

      // Reset in the middle of the write pulse
      req_valid = 1'b1; req_we = 1'b1; req_addr = 15'h0200; req_wdata = 8'h77;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("mid_pulse_we_low", 32'(WE_bar), 0);
      #2 rst = 1'b1;
      #1;
      check("arst_we_bar", 32'(WE_bar), 1);
      check("arst_cs_bar", 32'(CS_bar), 1);
      check("arst_oe_bar", 32'(OE_bar), 1);
      check("arst_d_released", 32'(D), 32'h5A);
      check("arst_rsp_valid", 32'(rsp_valid), 0);
      @(posedge clk); #2;
      rst = 1'b0;
      #1;
      check("arst_ready_after", 32'(req_ready), 1);
      cnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         cnt += int'(rsp_valid) + int'(!CS_bar);
      end
      check("arst_no_response", 32'(cnt), 0);

      // WRITE_HOLD = 0 instance
      req_valid0 = 1'b1; req_we = 1'b1; req_addr = 15'h0300; req_wdata = 8'h55;
      @(posedge clk); #1;
      req_valid0 = 1'b0;
      lat = -1; cs_n = 0; we_n = 0; last_we = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (rsp_valid0) begin lat = k; break; end
         cs_n += int'(!CS_bar0);
         we_n += int'(!WE_bar0);
         if (!CS_bar0) last_we = WE_bar0;
         @(posedge clk); #1;
      end
      check("h0_latency", 32'(lat), 3);
      check("h0_cs_cycles", 32'(cs_n), 3);
      check("h0_we_cycles", 32'(we_n), 2);
      check("h0_we_low_at_cs_end", 32'(last_we), 0);
      check("h0_strobes_at_rsp", {30'd0, CS_bar0, WE_bar0}, 3);
      check("h0_mem_written", 32'(mem0[15'h0300]), 32'h55);

      // Randomized traffic against the reference memory
      last_rd = 8'h00;
      for (int n = 0; n < 1000; n++) begin
         wr  = 1'($urandom_range(0, 1));
         idx = $urandom_range(0, 15);
         wd  = 8'($urandom);
         if (wr) begin
            ref_mem[idx] = wd;
            exp_rd = last_rd;
         end else begin
            exp_rd  = ref_mem[idx];
            last_rd = exp_rd;
         end
         do_txn(wr, AW'(16'h100 + idx), wd, lat, cs_n, oe_n, we_n, rdy_n);
         check("rand_latency", 32'(lat), wr ? 32'd4 : 32'd2);
         check("rand_rdata", 32'(rsp_rdata), 32'(exp_rd));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      check("bus_invariants", 32'(viol), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/async_mem_master.md
Name: async_mem_master

Overview:
- Synchronous bus initiator that drives the asynchronous parallel memory interface used by the ROM/SRAM parts (A, CS_bar, OE_bar, WE_bar, 8-bit D).
- Converts single-beat read/write requests from the processor core into correctly timed strobe sequences, with programmable wait states.
- Sits between the CPU memory port and one ROM/SRAM chip select.

Parameters:
- ADDR_WIDTH, 15, memory address width.
- READ_WAIT, 2, cycles CS_bar/OE_bar are held low before D is sampled (>=1).
- WRITE_SETUP, 1, cycles A/D/CS_bar are valid before WE_bar falls (>=1).
- WRITE_PULSE, 2, cycles WE_bar is held low (>=1).
- WRITE_HOLD, 1, cycles A/D/CS_bar are held after WE_bar rises (>=0).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  request address.
- req_wdata  input  8  write data.
- req_ready  output  1  block can accept a request this cycle.
- rsp_valid  output  1  one-cycle pulse: transaction complete.
- rsp_rdata  output  8  read data, valid when rsp_valid follows a read.
- A  output  ADDR_WIDTH  memory address.
- D  inout  8  memory data bus; driven only during write states, high-Z otherwise.
- CS_bar  output  1  chip select, active low.
- OE_bar  output  1  output enable, active low.
- WE_bar  output  1  write enable, active low.

Behaviour:
- Clocking and reset:
  - One clock domain.
  - rst is asynchronous and active-high.
  - Every output except req_ready and D comes from a register. No combinational glitches on the strobes.
- Reset values (applied immediately when rst asserts):
  - state IDLE; CS_bar = OE_bar = WE_bar = 1; A = 0; D high-Z.
  - rsp_valid = 0; rsp_rdata = 0; req_ready = 1 once rst deasserts.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD. A down-counter loads on every state entry. Its width fits the largest parameter.
- Handshake:
  - req_ready = 1 only in IDLE.
  - A request is accepted at the rising edge where req_valid && req_ready. At that edge req_we, req_addr and req_wdata are latched.
  - Request inputs are ignored at all other times.
  - At most one transaction is outstanding. There is no queue.
- Read (accept at edge E0):
  - IDLE->RD. From E0: A = addr, CS_bar = 0, OE_bar = 0, WE_bar = 1.
  - RD lasts READ_WAIT cycles. At edge E0+READ_WAIT, D is sampled into rsp_rdata and rsp_valid = 1 for one cycle. At the same edge CS_bar and OE_bar return to 1 and the state returns to IDLE.
  - Read latency from acceptance to rsp_valid = READ_WAIT cycles.
- Write (accept at E0):
  - WR_SETUP, WRITE_SETUP cycles: CS_bar = 0, A = addr, D driven with wdata, WE_bar = 1, OE_bar = 1.
  - WR_PULSE, WRITE_PULSE cycles: WE_bar = 0; A and D unchanged.
  - WR_HOLD, WRITE_HOLD cycles: WE_bar = 1, CS_bar = 0, A and D unchanged. Skipped entirely when WRITE_HOLD = 0.
  - On the final edge: CS_bar = 1, D released, rsp_valid pulses one cycle, state returns to IDLE. rsp_rdata is unchanged by writes.
  - Total write latency = WRITE_SETUP + WRITE_PULSE + WRITE_HOLD cycles.
- Invariants:
  - OE_bar = 0 and D-driven are never true in the same cycle.
  - WE_bar = 0 only while CS_bar = 0.
  - A and D are stable for the whole time CS_bar = 0.
- Turnaround:
  - rsp_valid coincides with the first IDLE cycle. A new request may be accepted at the edge ending that cycle.
  - This guarantees at least one cycle with all strobes high between transactions.
- Back-to-back:
  - A request held on req_valid during a transaction is accepted at the first IDLE edge.
  - Transactions complete in issue order.
- Reset mid-transaction:
  - Strobes go high and D is released asynchronously.
  - The transaction is dropped and no rsp_valid is produced.
  - An in-progress write may be partial. This is permitted.
- Address wrap: A is passed through unchanged. Full-width addresses such as 0x7FFF are legal.

Test Plan:
- Read, READ_WAIT=2, model ROM holding 0xA5 at 0x1234: request read 0x1234 -> CS_bar/OE_bar low for exactly 2 cycles; rsp_valid 2 cycles after accept with rsp_rdata = 0xA5; D never driven by the master.
- Write, 0x3C to 0x0010 with SETUP=1, PULSE=2, HOLD=1: WE_bar low for exactly 2 cycles; A = 0x0010 and D = 0x3C stable throughout CS_bar low; rsp_valid after 4 cycles; a following read of 0x0010 returns 0x3C.
- req_valid held high for write 0x7FFF then read 0x7FFF: req_ready low during each transaction; exactly one all-high strobe cycle between the two transactions; read returns the written value.
- WRITE_HOLD=0 instance, write 0x55 -> CS_bar rises on the same edge as WE_bar; no hold cycle; latency = 3 cycles.
- rst asserted mid-WR_PULSE: on the same timestep WE_bar/CS_bar = 1 and D = Z; no rsp_valid; req_ready = 1 in the first cycle after deassert.
- Bus-contention assertion, randomised 1000 mixed reads/writes: OE_bar low with D driven never occurs; every rsp_rdata matches a reference memory model.
